divider_16x8: RTL and testbench

DIVIDER_16X8 -- requirements
Module: divider_16x8

---
 rtl/divider_16x8.sv | 145 ++++++++++++++
 tb/tb_divider_16x8.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_16x8.sv
// rtl/divider_16x8.sv - 16/8 unsigned restoring shift-subtract divider, one quotient bit per clock
module divider_16x8 (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        St,
   input  logic [15:0] Dividend,
   input  logic [7:0]  Divisor,
   output logic        Idle,
   output logic        Done,
   output logic        V,
   output logic [7:0]  Quotient,
   output logic [7:0]  Remainder
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_DIV   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_dvd;
   logic [7:0]  r_dvs;
   logic [8:0]  r_prem;
   logic [7:0]  r_low;
   logic [2:0]  r_cnt;
   logic [7:0]  r_quot;
   logic [7:0]  r_rem;
   logic        r_v;

   logic        w_ovf;
   logic [9:0]  w_prem_sh;
   logic        w_qbit;
   logic [8:0]  w_prem_nx;
   logic [7:0]  w_low_nx;
   logic        w_idle;
   logic        w_done;

   // The quotient fits in 8 bits only when the high dividend byte is below the divisor;
   // a zero divisor is caught by the same test.
   assign w_ovf     = (r_dvs == 8'd0) || (r_dvd[15:8] >= r_dvs);

   // One restoring step: shift {partial remainder, low} left and trial-subtract the divisor.
   // The partial remainder always stays below the divisor, so the shifted value fits in 9 bits.
   assign w_prem_sh = {r_prem, r_low[7]};
   assign w_qbit    = (w_prem_sh >= {2'b00, r_dvs});
   assign w_prem_nx = 9'(w_qbit ? (w_prem_sh - {2'b00, r_dvs}) : w_prem_sh);
   assign w_low_nx  = {r_low[6:0], w_qbit};

   assign Idle      = w_idle;
   assign Done      = w_done;
   assign V         = r_v;
   assign Quotient  = r_quot;
   assign Remainder = r_rem;

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and Moore status outputs
   always_comb begin
      w_next = r_state;
      w_idle = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_idle = 1'b1;
            if (St) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            w_next = w_ovf ? S_DONE : S_DIV;
         end
         S_DIV: begin
            if (r_cnt == 3'd7) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Operand capture, iteration datapath and held result registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_dvd  <= 16'd0;
         r_dvs  <= 8'd0;
         r_prem <= 9'd0;
         r_low  <= 8'd0;
         r_cnt  <= 3'd0;
         r_quot <= 8'd0;
         r_rem  <= 8'd0;
         r_v    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (St) begin
                  r_dvd <= Dividend;
                  r_dvs <= Divisor;
                  r_v   <= 1'b0;
               end
            end
            S_CHECK: begin
               if (w_ovf) begin
                  r_v    <= 1'b1;
                  r_quot <= 8'd0;
                  r_rem  <= 8'd0;
               end else begin
                  r_prem <= {1'b0, r_dvd[15:8]};
                  r_low  <= r_dvd[7:0];
                  r_cnt  <= 3'd0;
               end
            end
            S_DIV: begin
               r_prem <= w_prem_nx;
               r_low  <= w_low_nx;
               r_cnt  <= r_cnt + 3'd1;
               // Results are published together with the move to DONE and then held.
               if (r_cnt == 3'd7) begin
                  r_quot <= w_low_nx;
                  r_rem  <= w_prem_nx[7:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_16x8.sv
// tb/tb_divider_16x8.sv - directed self-checking bench for divider_16x8
module tb_divider_16x8;

   logic        Clk;
   logic        Rst_n;
   logic        St;
   logic [15:0] Dividend;
   logic [7:0]  Divisor;
   logic        Idle;
   logic        Done;
   logic        V;
   logic [7:0]  Quotient;
   logic [7:0]  Remainder;

   int errors;
   int checks;

   divider_16x8 dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .St        (St),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Idle      (Idle),
      .Done      (Done),
      .V         (V),
      .Quotient  (Quotient),
      .Remainder (Remainder)
   );

   // 10 ns clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Start one division from IDLE and check latency, results and hold behaviour.
   task automatic do_div(input string name, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ev,
                         input int elat);
      int  n;
      bit  seen;
      checks++;
      if (Idle !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_before_start: got %b want 1", name, Idle);
      end
      Dividend = a;
      Divisor  = b;
      St       = 1'b1;
      @(posedge Clk); #1;
      St       = 1'b0;
      Dividend = ~a;
      Divisor  = b + 8'd3;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge Clk); #1;
         n++;
         if (Done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no Done within %0d edges", name, n);
      end else begin
         checks++;
         if (n != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, n, elat);
         end
      end
      checks++;
      if (Quotient !== eq) begin
         errors++;
         $display("FAIL %s quotient: got %h want %h", name, Quotient, eq);
      end
      checks++;
      if (Remainder !== er) begin
         errors++;
         $display("FAIL %s remainder: got %h want %h", name, Remainder, er);
      end
      checks++;
      if (V !== ev) begin
         errors++;
         $display("FAIL %s v_flag: got %b want %b", name, V, ev);
      end
      checks++;
      if (Idle !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_during_done: got %b want 0", name, Idle);
      end
      @(posedge Clk); #1;
      checks++;
      if (Done !== 1'b0 || Idle !== 1'b1) begin
         errors++;
         $display("FAIL %s after_done: got Done=%b Idle=%b want Done=0 Idle=1", name, Done, Idle);
      end
      checks++;
      if (Quotient !== eq || Remainder !== er || V !== ev) begin
         errors++;
         $display("FAIL %s hold: got Q=%h R=%h V=%b want Q=%h R=%h V=%b",
                  name, Quotient, Remainder, V, eq, er, ev);
      end
   endtask

   task automatic test_reset();
      Rst_n    = 1'b0;
      St       = 1'b0;
      Dividend = 16'd0;
      Divisor  = 8'd0;
      #3;
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0 || V !== 1'b0 || Quotient !== 8'd0 || Remainder !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got Idle=%b Done=%b V=%b Q=%h R=%h want 1 0 0 00 00",
                  Idle, Done, V, Quotient, Remainder);
      end
      @(posedge Clk); #1;
      @(posedge Clk); #3;
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      // First edge after release was already a normal IDLE edge with St low.
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got Idle=%b Done=%b want 1 0", Idle, Done);
      end
   endtask

   task automatic test_normal();
      do_div("div_100_7",    16'd100,  8'd7,    8'd14,   8'd2,    1'b0, 9);
      do_div("div_1234_56",  16'h1234, 8'h56,   8'h36,   8'h10,   1'b0, 9);
      do_div("div_small",    16'h0003, 8'h02,   8'h01,   8'h01,   1'b0, 9);
   endtask

   task automatic test_overflow();
      do_div("ovf_0500_05",  16'h0500, 8'h05,   8'h00,   8'h00,   1'b1, 1);
      do_div("ovf_div0",     16'h0500, 8'h00,   8'h00,   8'h00,   1'b1, 1);
      do_div("max_feff_ff",  16'hFEFF, 8'hFF,   8'hFF,   8'hFE,   1'b0, 9);
   endtask

   task automatic test_reset_mid_op();
      Dividend = 16'd100;
      Divisor  = 8'd7;
      St       = 1'b1;
      @(posedge Clk); #1;
      St = 1'b0;
      repeat (4) begin
         @(posedge Clk); #1;
      end
      #2;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0 || V !== 1'b0 || Quotient !== 8'd0 || Remainder !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_op: got Idle=%b Done=%b V=%b Q=%h R=%h want 1 0 0 00 00",
                  Idle, Done, V, Quotient, Remainder);
      end
      #2;
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      do_div("after_reset_100_7", 16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
   endtask

   task automatic test_back_to_back();
      bit exp_done;
      bit exp_idle;
      int n;
      Dividend = 16'd100;
      Divisor  = 8'd7;
      St       = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(posedge Clk); #1;
         exp_done = ((k % 11) == 9);
         exp_idle = ((k % 11) == 10);
         checks++;
         if (Done !== exp_done || Idle !== exp_idle) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got Done=%b Idle=%b want Done=%b Idle=%b",
                     k, Done, Idle, exp_done, exp_idle);
         end
         if (exp_done) begin
            checks++;
            if (Quotient !== 8'd14 || Remainder !== 8'd2 || V !== 1'b0) begin
               errors++;
               $display("FAIL b2b_result%0d: got Q=%h R=%h V=%b want 0e 02 0", k, Quotient, Remainder, V);
            end
         end
      end
      St = 1'b0;
      n = 0;
      while (Done !== 1'b1 && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      checks++;
      if (n != 7) begin
         errors++;
         $display("FAIL b2b_drain: got Done after %0d edges want 7", n);
      end
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop: got Idle=%b Done=%b want 1 0", Idle, Done);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_normal();
      test_overflow();
      test_reset_mid_op();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
